fp_addsub_seq: RTL



---
 rtl/fp_addsub_pkg.sv | 45 ++++
 rtl/fp_addsub_seq_sign.sv | 24 ++
 rtl/fp_addsub_seq.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fp_addsub_pkg.sv
// Shared types and constant helpers for the sequential floating-point adder/subtractor.
// Width helpers take the format parameters so one package serves any instantiation.
package fp_addsub_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_DONE
  } state_t;

  localparam int DEF_EXP_W = 5;
  localparam int DEF_MAN_W = 10;
  localparam int DEF_GRD_W = 2;

  // Working mantissa layout: {carry, hidden, frac, guard}
  function automatic int mant_width(input int man_w, input int grd_w);
    return man_w + grd_w + 2;
  endfunction

  // Beyond this many right shifts the smaller operand is entirely gone
  function automatic int max_shift(input int man_w, input int grd_w);
    return man_w + grd_w + 1;
  endfunction

  function automatic int exp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [63:0] zero_word();
    return '0;
  endfunction

  function automatic logic [63:0] max_finite(input int exp_w, input int man_w, input logic sign);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 63; i++) begin
      if (i < exp_w + man_w) r[i] = 1'b1;
    end
    r[exp_w + man_w] = sign;
    return r;
  endfunction

endpackage

// File: rtl/fp_addsub_seq_sign.sv
// Final result sign: the operand with the larger magnitude wins, exact zero is always +0.
module fp_sign_resolve
  import fp_addsub_pkg::*;
(
  input  logic exp_diffsig,
  input  logic exp_equal,
  input  logic mant_diffsig,
  input  logic sign_a,
  input  logic sign_b,
  input  logic zero_result,
  output logic sign
);

  always_comb begin
    sign = sign_a;
    if (zero_result)
      sign = 1'b0;
    else if (exp_diffsig)
      sign = sign_b;
    else if (exp_equal && mant_diffsig)
      sign = sign_b;
  end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point add/subtract: bit-serial alignment and normalisation,
// truncating pack with saturation on overflow and flush-to-zero on underflow.
module fp_addsub_seq
  import fp_addsub_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W,
  parameter int GRD_W = DEF_GRD_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   op,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   y,
  output logic                   ovf,
  output logic                   unf
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int WM = mant_width(MAN_W, GRD_W);
  localparam int MS = max_shift(MAN_W, GRD_W);
  localparam int CW = $clog2(MS + 1);
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] EXP_TOP = EW'((1 << EXP_W) - 1);

  state_t state, state_nxt;

  logic                 sign_a_r, sign_b_r, swap_r, exp_eq_r, sign_r;
  logic [WM-1:0]        mant_l, mant_s;
  logic [CW-1:0]        cnt;
  logic signed [EW-1:0] exp_r;

  // Operand unpack and exponent compare
  logic [EXP_W-1:0] exp_a, exp_b, exp_max, exp_dist;
  logic [WM-1:0]    mant_a_in, mant_b_in;
  logic             a_lt_b;
  logic [CW-1:0]    cnt_init;

  assign exp_a     = a[W-2:MAN_W];
  assign exp_b     = b[W-2:MAN_W];
  assign mant_a_in = (exp_a == '0) ? '0 : {2'b01, a[MAN_W-1:0], {GRD_W{1'b0}}};
  assign mant_b_in = (exp_b == '0) ? '0 : {2'b01, b[MAN_W-1:0], {GRD_W{1'b0}}};
  assign a_lt_b    = (exp_a < exp_b);
  assign exp_max   = a_lt_b ? exp_b : exp_a;
  assign exp_dist  = a_lt_b ? (exp_b - exp_a) : (exp_a - exp_b);
  assign cnt_init  = (int'(exp_dist) > MS) ? CW'(MS) : CW'(exp_dist);

  // Add/subtract on aligned magnitudes
  logic          eff_sub, l_ge_s, mant_diffsig, zero_sum, sign_res;
  logic [WM-1:0] mant_a_al, mant_b_al, sum;

  assign eff_sub      = sign_a_r ^ sign_b_r;
  assign l_ge_s       = (mant_l >= mant_s);
  assign mant_a_al    = swap_r ? mant_s : mant_l;
  assign mant_b_al    = swap_r ? mant_l : mant_s;
  assign mant_diffsig = (mant_b_al > mant_a_al);

  always_comb begin
    sum = mant_l + mant_s;
    if (eff_sub)
      sum = l_ge_s ? (mant_l - mant_s) : (mant_s - mant_l);
  end

  assign zero_sum = (sum == '0);

  fp_sign_resolve u_sign (
    .exp_diffsig (swap_r),
    .exp_equal   (exp_eq_r),
    .mant_diffsig(mant_diffsig),
    .sign_a      (sign_a_r),
    .sign_b      (sign_b_r),
    .zero_result (zero_sum),
    .sign        (sign_res)
  );

  // Normalisation decision and pack
  logic         carry, hidden, mant_zero, exp_pos, norm_done;
  logic [W-1:0] pack_y;
  logic         pack_ovf, pack_unf;

  assign carry     = mant_l[WM-1];
  assign hidden    = mant_l[WM-2];
  assign mant_zero = (mant_l == '0);
  assign exp_pos   = !exp_r[EW-1] && (exp_r != '0);
  assign norm_done = mant_zero || (!carry && (hidden || !exp_pos));

  always_comb begin
    pack_y   = {sign_r, exp_r[EXP_W-1:0], mant_l[WM-3:GRD_W]};
    pack_ovf = 1'b0;
    pack_unf = 1'b0;
    if (mant_zero) begin
      pack_y = W'(zero_word());
    end else if (exp_r > EXP_TOP) begin
      pack_y   = W'(max_finite(EXP_W, MAN_W, sign_r));
      pack_ovf = 1'b1;
    end else if (!exp_pos) begin
      pack_y   = W'(zero_word());
      pack_unf = 1'b1;
    end
  end

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = S_ALIGN;
      S_ALIGN: if (cnt <= CW'(1)) state_nxt = S_ADD;
      S_ADD:   state_nxt = S_NORM;
      S_NORM:  if (norm_done) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      swap_r   <= 1'b0;
      exp_eq_r <= 1'b0;
      sign_r   <= 1'b0;
      mant_l   <= '0;
      mant_s   <= '0;
      cnt      <= '0;
      exp_r    <= '0;
      y        <= '0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sign_a_r <= a[W-1];
            sign_b_r <= b[W-1] ^ op;
            swap_r   <= a_lt_b;
            exp_eq_r <= (exp_a == exp_b);
            mant_l   <= a_lt_b ? mant_b_in : mant_a_in;
            mant_s   <= a_lt_b ? mant_a_in : mant_b_in;
            cnt      <= cnt_init;
            exp_r    <= $signed(EW'(exp_max));
          end
        end
        S_ALIGN: begin
          if (cnt != '0) begin
            mant_s <= mant_s >> 1;
            cnt    <= cnt - CW'(1);
          end
        end
        S_ADD: begin
          mant_l <= sum;
          sign_r <= sign_res;
        end
        S_NORM: begin
          if (norm_done) begin
            y   <= pack_y;
            ovf <= pack_ovf;
            unf <= pack_unf;
          end else if (carry) begin
            mant_l <= mant_l >> 1;
            exp_r  <= exp_r + EW'(1);
          end else begin
            mant_l <= mant_l << 1;
            exp_r  <= exp_r - EW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
